// File: rtl/hud_digit_writer_if.sv
// Handshake and data bundle between a HUD refresh requester and hud_digit_writer.
interface hud_digit_writer_if;
    logic        start;
    logic [5:0]  field_en;
    logic [13:0] val0;
    logic [6:0]  val1;
    logic [6:0]  val2;
    logic [6:0]  val3;
    logic [6:0]  val4;
    logic [6:0]  val5;
    logic        write;
    logic [3:0]  num;
    logic [3:0]  blob;
    logic        busy;
    logic        done;

    modport master (
        output start, field_en, val0, val1, val2, val3, val4, val5,
        input  write, num, blob, busy, done
    );

    modport slave (
        input  start, field_en, val0, val1, val2, val3, val4, val5,
        output write, num, blob, busy, done
    );
endinterface

// File: rtl/hud_digit_writer.sv
// Converts six binary HUD fields to BCD (serial double-dabble) and streams the
// digits, most significant first, into a 14-slot digit store.
module hud_digit_writer #(
    parameter bit         LEAD_BLANK = 1'b0,
    parameter logic [3:0] BLANK_CODE = 4'hF
) (
    input logic               clk,
    input logic               rst_n,
    hud_digit_writer_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StScan, StConv, StEmit, StFin} state_t;

    state_t            state_q, state_d;
    logic [2:0]        fld_q, fld_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [1:0]        emit_q, emit_d;
    logic              seen_q, seen_d;
    logic [5:0]        en_q, en_d;
    logic [13:0]       v0_q, v0_d;
    logic [4:0][6:0]   vk_q, vk_d;
    logic [13:0]       bin_q, bin_d;
    logic [15:0]       bcd_q, bcd_d;
    logic              write_q, write_d;
    logic [3:0]        num_q, num_d;
    logic [3:0]        blob_q, blob_d;

    logic [13:0]       sat0;
    logic [4:0][6:0]   satk;
    logic [6:0]        vk_sel;
    logic              field_zero;
    logic [1:0]        ndig_last;
    logic [3:0]        last_bit;
    logic [13:0]       load_bin;
    logic [3:0]        blob_base;
    logic [11:0]       adj;
    logic [15:0]       step_bcd;
    logic [13:0]       step_bin;

    logic              do_emit, emit_first;
    logic [15:0]       emit_src;
    logic [1:0]        emit_sel;
    logic [3:0]        digit;
    logic              seen_prev, blank;

    // Input saturation and per-field parameters for the field under scan.
    always_comb begin
        sat0 = (bus.val0 > 14'd9999) ? 14'd9999 : bus.val0;
        satk[0] = (bus.val1 > 7'd99) ? 7'd99 : bus.val1;
        satk[1] = (bus.val2 > 7'd99) ? 7'd99 : bus.val2;
        satk[2] = (bus.val3 > 7'd99) ? 7'd99 : bus.val3;
        satk[3] = (bus.val4 > 7'd99) ? 7'd99 : bus.val4;
        satk[4] = (bus.val5 > 7'd99) ? 7'd99 : bus.val5;
        unique case (fld_q)
            3'd1:    vk_sel = vk_q[0];
            3'd2:    vk_sel = vk_q[1];
            3'd3:    vk_sel = vk_q[2];
            3'd4:    vk_sel = vk_q[3];
            default: vk_sel = vk_q[4];
        endcase
        field_zero = (fld_q == 3'd0);
        ndig_last  = field_zero ? 2'd3 : 2'd1;
        last_bit   = field_zero ? 4'd13 : 4'd6;
        // Two-digit fields are left-aligned so the same MSB-first shifter serves all.
        load_bin   = field_zero ? v0_q : {vk_sel, 7'd0};
        blob_base  = field_zero ? 4'd0 : ({fld_q, 1'b0} + 4'd2);
    end

    // One double-dabble step. The thousands nibble never needs correction since
    // saturated inputs keep it at 4 or less before every shift.
    always_comb begin
        adj = bcd_q[11:0];
        for (int i = 0; i < 3; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        step_bcd = {bcd_q[14:12], adj, bin_q[13]};
        step_bin = {bin_q[12:0], 1'b0};
    end

    // Next-state, datapath and write-strobe decode.
    always_comb begin
        state_d    = state_q;
        fld_d      = fld_q;
        cnt_d      = cnt_q;
        emit_d     = emit_q;
        seen_d     = seen_q;
        en_d       = en_q;
        v0_d       = v0_q;
        vk_d       = vk_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        write_d    = 1'b0;
        num_d      = num_q;
        blob_d     = blob_q;
        do_emit    = 1'b0;
        emit_first = 1'b0;
        emit_src   = bcd_q;
        emit_sel   = 2'd0;

        unique case (state_q)
            StIdle, StFin: begin
                state_d = StIdle;
                if (bus.start) begin
                    en_d    = bus.field_en;
                    v0_d    = sat0;
                    vk_d    = satk;
                    fld_d   = 3'd0;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (en_q[fld_q]) begin
                    bin_d   = load_bin;
                    bcd_d   = 16'd0;
                    cnt_d   = 4'd0;
                    state_d = StConv;
                end else if (fld_q == 3'd5) begin
                    state_d = StFin;
                end else begin
                    fld_d = fld_q + 3'd1;
                end
            end
            StConv: begin
                bin_d = step_bin;
                bcd_d = step_bcd;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == last_bit) begin
                    // First digit goes out on the same edge the conversion completes.
                    state_d    = StEmit;
                    emit_d     = 2'd0;
                    do_emit    = 1'b1;
                    emit_first = 1'b1;
                    emit_src   = step_bcd;
                    emit_sel   = ndig_last;
                end
            end
            StEmit: begin
                if (emit_q == ndig_last) begin
                    if (fld_q == 3'd5) begin
                        state_d = StFin;
                    end else begin
                        fld_d   = fld_q + 3'd1;
                        state_d = StScan;
                    end
                end else begin
                    emit_d   = emit_q + 2'd1;
                    do_emit  = 1'b1;
                    emit_sel = ndig_last - emit_q - 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        digit     = emit_src[{emit_sel, 2'b00} +: 4];
        seen_prev = emit_first ? 1'b0 : seen_q;
        blank     = LEAD_BLANK && !seen_prev && (digit == 4'd0) && (emit_sel != 2'd0);
        if (do_emit) begin
            write_d = 1'b1;
            num_d   = blank ? BLANK_CODE : digit;
            blob_d  = blob_base + {2'b00, ndig_last - emit_sel};
            seen_d  = seen_prev | (digit != 4'd0);
        end
    end

    // State, latched inputs and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            fld_q   <= 3'd0;
            cnt_q   <= 4'd0;
            emit_q  <= 2'd0;
            seen_q  <= 1'b0;
            en_q    <= 6'd0;
            v0_q    <= 14'd0;
            vk_q    <= '0;
            bin_q   <= 14'd0;
            bcd_q   <= 16'd0;
            write_q <= 1'b0;
            num_q   <= 4'd0;
            blob_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            cnt_q   <= cnt_d;
            emit_q  <= emit_d;
            seen_q  <= seen_d;
            en_q    <= en_d;
            v0_q    <= v0_d;
            vk_q    <= vk_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            write_q <= write_d;
            num_q   <= num_d;
            blob_q  <= blob_d;
        end
    end

    assign bus.write = write_q;
    assign bus.num   = num_q;
    assign bus.blob  = blob_q;
    assign bus.busy  = (state_q == StScan) || (state_q == StConv) || (state_q == StEmit);
    assign bus.done  = (state_q == StFin);
endmodule

// File: doc/hud_digit_writer.md
HUD_DIGIT_WRITER -- requirements
Module: hud_digit_writer

Interface
REQ-001 SHALL have parameter LEAD_BLANK, default 0: 1 = suppress leading zeros in each field.
REQ-002 SHALL have parameter BLANK_CODE, default 4'hF: digit code written in place of a suppressed leading zero.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request a HUD refresh.
REQ-006 SHALL have port field_en, input, 6 bits: bit k enables rewrite of field k.
REQ-007 SHALL have port val0, input, 14 bits: binary value of field 0 (4 digits, blobs 0-3).
REQ-008 SHALL have ports val1..val5, input, 7 bits each: binary values of fields 1..5 (2 digits each, blobs 4-5, 6-7, 8-9, 10-11, 12-13).
REQ-009 SHALL have port write, output, 1 bit: digit write strobe to the HUD digit store.
REQ-010 SHALL have port num, output, 4 bits: digit code accompanying write.
REQ-011 SHALL have port blob, output, 4 bits: target digit slot 0-13 accompanying write.
REQ-012 SHALL have port busy, output, 1 bit: a refresh is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse on refresh completion.

Function
REQ-014 SHALL use states IDLE, SCAN, CONV, EMIT, FIN.
REQ-015 SHALL accept start only in IDLE; at acceptance edge T0 it SHALL latch val0-val5 and field_en, and enter SCAN for field 0.
REQ-016 SHALL ignore start while busy; values changed after T0 SHALL NOT affect the refresh.
REQ-017 SCAN SHALL take 1 cycle per field: for an enabled field, go to CONV; for a disabled field, go to the next field's SCAN; after field 5, go to FIN.
REQ-018 SHALL saturate before conversion: val0 > 9999 -> 9999; valk > 99 -> 99.
REQ-019 CONV SHALL be sequential shift-add-3 (double-dabble), one bit per cycle: 14 cycles for field 0, 7 cycles for fields 1-5.
REQ-020 EMIT SHALL issue one write per cycle, most significant digit first, at ascending blob indices (field 0: blobs 0,1,2,3; field k: blobs 2k+2, 2k+3).
REQ-021 Digit codes SHALL be BCD 0-9; with LEAD_BLANK=1, every zero digit above the first nonzero digit SHALL be BLANK_CODE; the least significant digit SHALL never be blanked.
REQ-022 write, num and blob SHALL be registered; num and blob SHALL hold their last values when write=0.
REQ-023 Refresh length SHALL be L = 6 + 18*en0 + 9*(en1+...+en5) cycles.
REQ-024 busy SHALL be high in cycles T0+1 .. T0+L.
REQ-025 FIN SHALL pulse done high for exactly cycle T0+L+1, with busy low in that cycle, then return to IDLE.
REQ-026 start asserted during the done cycle SHALL be accepted, so back-to-back refreshes lose no cycle.
REQ-027 No write SHALL occur outside EMIT, and exactly 4*en0 + 2*(en1+...+en5) writes SHALL occur per refresh.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE and write=0, num=0, blob=0, busy=0, done=0, and clear all latched values.
REQ-029 Reset during a refresh SHALL abort it; no further write or done SHALL occur until a new start.
REQ-030 After rst_n rises, the block SHALL accept start on the first clock edge.

Verification
REQ-031 Full refresh: field_en=6'h3F, val0=1234, val1..val5=5,17,99,0,42, LEAD_BLANK=0 -> 14 writes (blob,num) = (0,1)(1,2)(2,3)(3,4)(4,0)(5,5)(6,1)(7,7)(8,9)(9,9)(10,0)(11,0)(12,4)(13,2); done at T0+70.
REQ-032 Saturation: val0=16383, val3=127, field_en=6'b001001 -> writes (0-3: 9,9,9,9) and (8,9)(9,9); done at T0+34.
REQ-033 Empty mask: field_en=0 -> no writes; busy high for 6 cycles; done at T0+7.
REQ-034 Blanking: LEAD_BLANK=1, val0=7, val1=0, field_en=6'b000011 -> (0,F)(1,F)(2,F)(3,7)(4,F)(5,0).
REQ-035 Abort and busy handling: rst_n low at T0+10 -> outputs 0 at once, no done; new start after release gives a correct full refresh; start pulsed while busy -> ignored, and exactly one done.
